src_voice_sched: RTL and testbench

Per-frame voice scheduler that time-shares one sample-generation engine (a `src_sine`-class source) between `NUM_VOICES` voices. On each rising edge of `pblrc` it walks the enabled voices in index order and presents each voice's frequency and volume to the engine over a req/ack handshake. It accumulates the returned signed samples and emits one saturated mixed sample per frame toward the I2S transmit path. Voice configuration arrives through a small write port into shadow registers, and those take effect only at frame boundaries.

---
 rtl/src_voice_sched.sv | 163 ++++++++++++++++
 tb/tb_src_voice_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/src_voice_sched.sv
// Frame-rate voice scheduler: time-shares one sample engine across NUM_VOICES voices
// per pblrc frame and emits one saturated mixed sample per frame.
module src_voice_sched #(
  parameter  int NUM_VOICES    = 4,
  parameter  int FREQ_RES_BITS = 8,
  parameter  int VOLUME_BITS   = 8,
  parameter  int SAMPLE_BITS   = 16,
  localparam int VW            = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                     mclk,
  input  logic                     rst,
  input  logic                     pblrc,
  input  logic                     cfg_we,
  input  logic [VW-1:0]            cfg_addr,
  input  logic [FREQ_RES_BITS-1:0] cfg_freq,
  input  logic [VOLUME_BITS-1:0]   cfg_vol,
  input  logic                     cfg_en,
  output logic                     eng_req,
  output logic [VW-1:0]            eng_voice,
  output logic [FREQ_RES_BITS-1:0] eng_freq,
  output logic [VOLUME_BITS-1:0]   eng_vol,
  input  logic                     eng_ack,
  input  logic [SAMPLE_BITS-1:0]   eng_sample,
  output logic [SAMPLE_BITS-1:0]   mix_sample,
  output logic                     mix_valid,
  output logic                     overrun
);
  localparam int AW    = SAMPLE_BITS + $clog2(NUM_VOICES) + 1;
  localparam int LASTI = NUM_VOICES - 1;
  localparam logic [VW-1:0] LAST   = LASTI[VW-1:0];
  localparam logic [VW:0]   NV_CNT = NUM_VOICES[VW:0];
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_ACC, S_DONE} state_t;

  state_t state, state_nx;

  logic [NUM_VOICES-1:0]                    sh_en, act_en;
  logic [NUM_VOICES-1:0][FREQ_RES_BITS-1:0] sh_freq, act_freq;
  logic [NUM_VOICES-1:0][VOLUME_BITS-1:0]   sh_vol, act_vol;

  logic                   pb_s1, pb_s2, pb_s3, fs;
  logic [VW-1:0]          idx;
  logic signed [AW-1:0]   acc, acc_sum;
  logic [SAMPLE_BITS-1:0] samp_q;
  logic                   cur_en, last;

  function automatic logic [SAMPLE_BITS-1:0] sat(input logic signed [AW-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[SAMPLE_BITS-1:0];
    else if (a < SAT_MIN) return SAT_MIN[SAMPLE_BITS-1:0];
    else                  return a[SAMPLE_BITS-1:0];
  endfunction

  assign cur_en  = act_en[idx];
  assign last    = (idx == LAST);
  assign acc_sum = acc + AW'($signed(samp_q));

  // Shadow registers; the active set only picks these up in LOAD
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sh_en   <= '0;
      sh_freq <= '0;
      sh_vol  <= '0;
    end else if (cfg_we && ({1'b0, cfg_addr} < NV_CNT)) begin
      sh_en[cfg_addr]   <= cfg_en;
      sh_freq[cfg_addr] <= cfg_freq;
      sh_vol[cfg_addr]  <= cfg_vol;
    end
  end

  // pblrc synchroniser plus registered rising-edge pulse
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      pb_s1 <= 1'b0;
      pb_s2 <= 1'b0;
      pb_s3 <= 1'b0;
      fs    <= 1'b0;
    end else begin
      pb_s1 <= pblrc;
      pb_s2 <= pb_s1;
      pb_s3 <= pb_s2;
      fs    <= pb_s2 & ~pb_s3;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (fs) state_nx = S_LOAD;
      S_LOAD: state_nx = S_REQ;
      S_REQ: begin
        if (cur_en)    state_nx = S_WAIT;
        else if (last) state_nx = S_DONE;
      end
      S_WAIT: if (eng_ack) state_nx = S_ACC;
      S_ACC:  state_nx = last ? S_DONE : S_REQ;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // mix_sample/mix_valid load on the edge entering DONE, so the strobe spans DONE
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      act_en     <= '0;
      act_freq   <= '0;
      act_vol    <= '0;
      acc        <= '0;
      idx        <= '0;
      samp_q     <= '0;
      eng_req    <= 1'b0;
      eng_voice  <= '0;
      eng_freq   <= '0;
      eng_vol    <= '0;
      mix_sample <= '0;
      mix_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (fs && state != S_IDLE) overrun <= 1'b1;
      unique case (state)
        S_LOAD: begin
          act_en   <= sh_en;
          act_freq <= sh_freq;
          act_vol  <= sh_vol;
          acc      <= '0;
          idx      <= '0;
        end
        S_REQ: begin
          if (cur_en) begin
            eng_req   <= 1'b1;
            eng_voice <= idx;
            eng_freq  <= act_freq[idx];
            eng_vol   <= act_vol[idx];
          end else if (last) begin
            mix_sample <= sat(acc);
            mix_valid  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_WAIT: if (eng_ack) samp_q <= eng_sample;
        S_ACC: begin
          acc     <= acc_sum;
          eng_req <= 1'b0;
          if (last) begin
            mix_sample <= sat(acc_sum);
            mix_valid  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_src_voice_sched.sv
// Bench for src_voice_sched: per-edge expectation timeline built from frame-level rules,
// random cfg/ack/sample stimulus, plus literal checks of the directed scenarios.
module tb_src_voice_sched;
  localparam int NV = 4, FB = 8, VB = 8, SB = 16, VW = 2, MAXC = 16384;

  logic          mclk = 1'b0, rst = 1'b0, pblrc = 1'b0;
  logic          cfg_we = 1'b0, cfg_en = 1'b0;
  logic [VW-1:0] cfg_addr = '0;
  logic [FB-1:0] cfg_freq = '0;
  logic [VB-1:0] cfg_vol = '0;
  logic          eng_ack = 1'b0;
  logic [SB-1:0] eng_sample = '0;
  logic          eng_req, mix_valid, overrun;
  logic [VW-1:0] eng_voice;
  logic [FB-1:0] eng_freq;
  logic [VB-1:0] eng_vol;
  logic [SB-1:0] mix_sample;

  src_voice_sched #(.NUM_VOICES(NV), .FREQ_RES_BITS(FB), .VOLUME_BITS(VB), .SAMPLE_BITS(SB)) dut (
    .mclk(mclk), .rst(rst), .pblrc(pblrc),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_freq(cfg_freq), .cfg_vol(cfg_vol), .cfg_en(cfg_en),
    .eng_req(eng_req), .eng_voice(eng_voice), .eng_freq(eng_freq), .eng_vol(eng_vol),
    .eng_ack(eng_ack), .eng_sample(eng_sample),
    .mix_sample(mix_sample), .mix_valid(mix_valid), .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // expectation timeline, indexed by the posedge after which the value holds
  bit exp_req[MAXC];
  int exp_v[MAXC], exp_f[MAXC], exp_vl[MAXC];
  bit exp_mv[MAXC];
  int exp_mx[MAXC];
  int ack_md[MAXC];  // 0 free/random, 1 forced low, 2 forced high with ack_sm
  int ack_sm[MAXC];

  bit sh_en[NV];
  int sh_f[NV], sh_v[NV];
  int pend_e = -1, model_t = 0, ov_edge = 0, pb_hi = 0;
  bit frc_on = 0, rand_cfg = 0;
  int frc_n = 0, stall_n = 0;
  int frc_s[NV];
  bit cw_we = 0, cw_en = 0;
  int cw_a = 0, cw_f = 0, cw_v = 0;
  int total = 0, bad = 0;

  function automatic int sx(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sat(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30) $display("FAIL %s at edge %0d: got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  // Frame-level rule: each voice in index order costs 1 cycle if disabled,
  // 3+N if enabled; the mix lands when the last voice is done.
  task automatic build_frame(input int e);
    int t, sum, n, s;
    logic [15:0] r;
    t = e + 4;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (!sh_en[v]) begin
        t++;
      end else begin
        n = frc_on ? frc_n : int'($urandom_range(0, 3));
        if (stall_n > 0) begin n = stall_n; stall_n = 0; end
        r = 16'($urandom);
        s = frc_on ? frc_s[v] : sx(r);
        for (int j = t + 1; j <= t + 2 + n; j++) begin
          exp_req[j] = 1'b1; exp_v[j] = v; exp_f[j] = sh_f[v]; exp_vl[j] = sh_v[v];
        end
        for (int j = t + 2; j <= t + 1 + n; j++) ack_md[j] = 1;
        ack_md[t + 2 + n] = 2;
        ack_sm[t + 2 + n] = s;
        sum += s;
        t += 3 + n;
      end
    end
    exp_mv[t] = 1'b1;
    exp_mx[t] = sat(sum);
    model_t = t;
  endtask

  // Sets every DUT input for the coming edge (cyc+1) and advances the model
  task automatic drive(input bit pb);
    int k, e, a;
    k = cyc;
    e = k + 1;
    if (pb && !pblrc && rst) begin
      if (pend_e < 0 && e >= model_t - 1) pend_e = e;
      else if (ov_edge == 0) ov_edge = e + 3;
    end
    pblrc = pb;
    if (pend_e >= 0 && k == pend_e + 3) begin
      build_frame(pend_e);
      pend_e = -1;
    end
    if (rst && cw_we) begin
      cfg_we = 1'b1; cfg_addr = VW'(cw_a); cfg_en = cw_en; cfg_freq = FB'(cw_f); cfg_vol = VB'(cw_v);
      sh_en[cw_a] = cw_en; sh_f[cw_a] = cw_f; sh_v[cw_a] = cw_v;
    end else if (rst && rand_cfg && $urandom_range(0, 3) == 0) begin
      a = int'($urandom_range(0, NV - 1));
      cfg_we = 1'b1; cfg_addr = VW'(a); cfg_en = ($urandom_range(0, 3) != 0);
      cfg_freq = FB'($urandom); cfg_vol = VB'($urandom);
      sh_en[a] = cfg_en; sh_f[a] = int'(cfg_freq); sh_v[a] = int'(cfg_vol);
    end else begin
      cfg_we = 1'b0; cfg_addr = VW'($urandom); cfg_en = 1'($urandom);
      cfg_freq = FB'($urandom); cfg_vol = VB'($urandom);
    end
    cw_we = 1'b0;
    if (e < MAXC && ack_md[e] == 2) begin
      eng_ack = 1'b1; eng_sample = SB'(ack_sm[e]);
    end else if (e < MAXC && ack_md[e] == 1) begin
      eng_ack = 1'b0; eng_sample = SB'($urandom);
    end else begin
      eng_ack = 1'($urandom); eng_sample = SB'($urandom);
    end
  endtask

  task automatic step();
    @(negedge mclk); #1;
    drive(cyc + 1 <= pb_hi);
  endtask

  task automatic kick(output int e);
    @(negedge mclk); #1;
    e = cyc + 1;
    pb_hi = e + 5;
    drive(1'b1);
  endtask

  task automatic go(input int e);
    while (cyc < e) step();
  endtask

  task automatic wcfg(input int a, input bit en, input int f, input int v);
    cw_we = 1'b1; cw_a = a; cw_en = en; cw_f = f; cw_v = v;
    step();
  endtask

  task automatic model_reset();
    for (int j = cyc + 1; j < MAXC; j++) begin
      exp_req[j] = 1'b0; exp_mv[j] = 1'b0; ack_md[j] = 0;
    end
    for (int v = 0; v < NV; v++) begin sh_en[v] = 1'b0; sh_f[v] = 0; sh_v[v] = 0; end
    pend_e = -1; model_t = 0; ov_edge = 0; pb_hi = 0; pblrc = 1'b0;
  endtask

  // per-edge compare against the timeline
  initial begin
    int k;
    int cur_mix;
    cur_mix = 0;
    forever begin
      @(negedge mclk);
      k = cyc;
      if (k < MAXC) begin
        if (!rst) cur_mix = 0;
        else if (exp_mv[k]) cur_mix = exp_mx[k];
        chk("eng_req", eng_req, exp_req[k]);
        if (exp_req[k]) begin
          chk("eng_voice", eng_voice, exp_v[k]);
          chk("eng_freq", eng_freq, exp_f[k]);
          chk("eng_vol", eng_vol, exp_vl[k]);
        end else if (!rst) begin
          chk("rst_fields", {eng_voice, eng_freq, eng_vol}, 0);
        end
        chk("mix_valid", mix_valid, exp_mv[k]);
        chk("mix_sample", mix_sample, cur_mix & 32'hFFFF);
        chk("overrun", overrun, (ov_edge != 0 && k >= ov_edge));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int e0, e1, e2;
    repeat (3) step();
    chk("reset_req", eng_req, 0);
    chk("reset_mv", mix_valid, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_mix", mix_sample, 0);
    rst = 1'b1;
    repeat (3) step();

    // single voice, ack after N=2 with 0x1234
    wcfg(0, 1'b1, 30, 63);
    frc_on = 1'b1; frc_n = 2; frc_s = '{sx(16'h1234), 0, 0, 0};
    for (int f = 0; f < 2; f++) begin
      kick(e0);
      go(e0 + 6);
      chk("single_req", eng_req, 1);
      chk("single_voice", eng_voice, 0);
      chk("single_freq", eng_freq, 30);
      chk("single_vol", eng_vol, 63);
      go(e0 + 12);
      chk("single_mv", mix_valid, 1);
      chk("single_mix", mix_sample, 32'h1234);
      go(e0 + 13);
      chk("single_mv_1cyc", mix_valid, 0);
      go(e0 + 20);
    end

    // saturation with all four voices, ack combinational (N=0)
    wcfg(1, 1'b1, 11, 21); wcfg(2, 1'b1, 12, 22); wcfg(3, 1'b1, 13, 23);
    frc_n = 0;
    frc_s = '{sx(16'h3000), sx(16'h3000), sx(16'h3000), sx(16'h3000)};
    kick(e0); go(e0 + 16);
    chk("sat_pos_mv", mix_valid, 1);
    chk("sat_pos", mix_sample, 32'h7FFF);
    go(e0 + 20);
    frc_s = '{sx(16'hD000), sx(16'hD000), sx(16'hD000), sx(16'hD000)};
    kick(e0); go(e0 + 16);
    chk("sat_neg", mix_sample, 32'h8000);
    go(e0 + 20);
    frc_s = '{sx(16'h7000), sx(16'h9000), sx(16'h0010), 0};
    kick(e0); go(e0 + 16);
    chk("sat_mixed", mix_sample, 32'h0010);
    go(e0 + 20);

    // all voices disabled
    for (int v = 0; v < NV; v++) wcfg(v, 1'b0, 0, 0);
    kick(e0); go(e0 + 8);
    chk("none_mv", mix_valid, 1);
    chk("none_mix", mix_sample, 0);
    go(e0 + 20);

    // shadow timing: write during WAIT, and on the LOAD edge
    wcfg(1, 1'b1, 10, 5);
    frc_n = 2; frc_s = '{0, sx(16'h0100), 0, 0};
    kick(e0); go(e0 + 6);
    chk("shadow_k_req", eng_req, 1);
    chk("shadow_k_freq", eng_freq, 10);
    cw_we = 1'b1; cw_a = 1; cw_en = 1'b1; cw_f = 40; cw_v = 5;
    step();
    go(e0 + 20);
    kick(e1); go(e1 + 3);
    cw_we = 1'b1; cw_a = 1; cw_en = 1'b1; cw_f = 50; cw_v = 5;
    step();
    go(e1 + 6);
    chk("shadow_k1_freq", eng_freq, 40);
    go(e1 + 20);
    kick(e2); go(e2 + 6);
    chk("shadow_load_freq", eng_freq, 50);
    go(e2 + 20);

    // overrun: first voice stalls 200 cycles, two frame starts arrive meanwhile
    frc_on = 1'b0; stall_n = 200;
    kick(e0);
    go(e0 + 40); kick(e1);
    go(e0 + 100); kick(e2);
    go(e0 + 110);
    chk("ovr_set", overrun, 1);
    go(e0 + 210);
    chk("ovr_mv", mix_valid, 1);
    go(e0 + 230);
    chk("ovr_sticky", overrun, 1);

    // reset in the middle of WAIT
    frc_on = 1'b1; frc_n = 3;
    kick(e0); go(e0 + 7);
    chk("pre_rst_req", eng_req, 1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_req_drop", eng_req, 0);
    chk("rst_ovr_clr", overrun, 0);
    chk("rst_fields_clr", {eng_voice, eng_freq, eng_vol}, 0);
    chk("rst_mix_clr", {mix_valid, mix_sample}, 0);
    repeat (3) step();
    rst = 1'b1;
    go(cyc + 30);
    chk("post_rst_mix", {mix_valid, mix_sample}, 0);

    // random configuration, samples, ack latency and frame spacing
    frc_on = 1'b0; rand_cfg = 1'b1;
    for (int f = 0; f < 70; f++) begin
      kick(e0);
      go(e0 + int'($urandom_range(18, 60)));
    end
    go(cyc + 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
